// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline interlock for a 5-stage (IF, DEC, EX, MEM, WB) MIPS core that has
// no forwarding.
//
// The block keeps a private 3-entry shadow of the instructions in EX, MEM and
// WB. It compares that shadow against the register and Hi/Lo reads of the
// instruction in DEC. From the result it decides, every cycle, between three
// actions:
//   - FLUSH: squash the wrong-path fetch on an EX redirect.
//   - STALL: hold PC and IF/DEC, and inject a bubble into DEC/EX.
//   - RUN:   advance normally.
// It also keeps saturating debug counts of STALL and FLUSH cycles.
//
// Ports
//   Clk            clock, all state updates on the rising edge
//   Rst            asynchronous active-low reset
//   dec_rs/rt      source register fields of the DEC instruction
//   dec_use_rs/rt  DEC instruction actually reads rs / rt
//   dec_dest       resolved destination register of the DEC instruction
//   dec_reg_write  DEC instruction may write the GPR file
//   dec_hilo_read  DEC instruction reads Hi or Lo
//   dec_hilo_write DEC instruction writes Hi or Lo
//   ex_redirect    taken branch / jump / jr resolving in EX this cycle
//   pc_write       PC load enable
//   ifdec_write    IF/DEC load enable
//   ifdec_flush    load a NOP into IF/DEC
//   decex_bubble   zero the control fields entering DEC/EX
//   ctrl_state     registered decision of the previous cycle
//   stall_cycles   saturating count of STALL cycles
//   flush_events   saturating count of FLUSH cycles
//
// States (ctrl_state)
//   state | meaning
//   RUN   | 00  pipeline advanced normally
//   STALL | 01  RAW hazard, DEC held and a bubble sent to EX
//   FLUSH | 10  EX redirect, wrong-path IF/DEC contents squashed
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter bit WB_HAZARD = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       dec_rs,
    input  logic [4:0]       dec_rt,
    input  logic             dec_use_rs,
    input  logic             dec_use_rt,
    input  logic [4:0]       dec_dest,
    input  logic             dec_reg_write,
    input  logic             dec_hilo_read,
    input  logic             dec_hilo_write,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             ifdec_write,
    output logic             ifdec_flush,
    output logic             decex_bubble,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } ctrl_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       hilo_write;
    } slot_t;

    localparam slot_t             SLOT_EMPTY = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             dec_valid_q,    dec_valid_d;
    slot_t            ex_slot_q,      ex_slot_d;
    slot_t            mem_slot_q,     mem_slot_d;
    slot_t            wb_slot_q,      wb_slot_d;
    ctrl_state_e      ctrl_state_q,   ctrl_state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    function automatic logic gpr_hit(input slot_t s,
                                     input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rt, input logic use_rt);
        logic rs_match;
        logic rt_match;
        rs_match = use_rs && (rs == s.dest);
        rt_match = use_rt && (rt == s.dest);
        // $0 is hard-wired, so a write to it can never create a dependence.
        return s.valid && s.reg_write && (s.dest != 5'd0) && (rs_match || rt_match);
    endfunction

    function automatic logic hilo_hit(input slot_t s, input logic hilo_read);
        return s.valid && s.hilo_write && hilo_read;
    endfunction

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic hazard;

    always_comb begin
        ex_hit  = gpr_hit(ex_slot_q, dec_rs, dec_use_rs, dec_rt, dec_use_rt)
                  || hilo_hit(ex_slot_q, dec_hilo_read);
        mem_hit = gpr_hit(mem_slot_q, dec_rs, dec_use_rs, dec_rt, dec_use_rt)
                  || hilo_hit(mem_slot_q, dec_hilo_read);
        // Without write-through in the register file, a read in DEC during the
        // WB write cycle would still see the old value, so WB must interlock too.
        wb_hit  = WB_HAZARD
                  && (gpr_hit(wb_slot_q, dec_rs, dec_use_rs, dec_rt, dec_use_rt)
                      || hilo_hit(wb_slot_q, dec_hilo_read));
        hazard  = dec_valid_q && (ex_hit || mem_hit || wb_hit);
    end

    // -------------------------------------------------------------------------
    // Decision and pipeline controls
    // -------------------------------------------------------------------------
    ctrl_state_e decision;

    always_comb begin
        decision = ST_RUN;
        if (ex_redirect) begin
            // A stalled DEC instruction is on the wrong path, so the redirect wins.
            decision = ST_FLUSH;
        end else if (hazard) begin
            decision = ST_STALL;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifdec_write  = 1'b1;
        ifdec_flush  = 1'b0;
        decex_bubble = 1'b0;
        if (!Rst) begin
            // Keep the core frozen on NOPs for as long as reset is held.
            pc_write     = 1'b0;
            ifdec_write  = 1'b0;
            ifdec_flush  = 1'b1;
            decex_bubble = 1'b1;
        end else begin
            unique case (decision)
                ST_FLUSH: begin
                    pc_write     = 1'b1;
                    ifdec_write  = 1'b1;
                    ifdec_flush  = 1'b1;
                    decex_bubble = 1'b1;
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    ifdec_write  = 1'b0;
                    ifdec_flush  = 1'b0;
                    decex_bubble = 1'b1;
                end
                default: begin
                    pc_write     = 1'b1;
                    ifdec_write  = 1'b1;
                    ifdec_flush  = 1'b0;
                    decex_bubble = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        dec_valid_d    = dec_valid_q;
        ex_slot_d      = SLOT_EMPTY;
        // MEM and WB shift unconditionally; only EX entry depends on the decision.
        mem_slot_d     = ex_slot_q;
        wb_slot_d      = mem_slot_q;
        ctrl_state_d   = decision;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;

        unique case (decision)
            ST_FLUSH: begin
                dec_valid_d = 1'b0;
                ex_slot_d   = SLOT_EMPTY;
                if (flush_events_q != CNT_MAX) begin
                    flush_events_d = flush_events_q + CNT_ONE;
                end
            end
            ST_STALL: begin
                dec_valid_d = dec_valid_q;
                ex_slot_d   = SLOT_EMPTY;
                if (stall_cycles_q != CNT_MAX) begin
                    stall_cycles_d = stall_cycles_q + CNT_ONE;
                end
            end
            default: begin
                dec_valid_d          = 1'b1;
                ex_slot_d.valid      = dec_valid_q;
                ex_slot_d.dest       = dec_dest;
                ex_slot_d.reg_write  = dec_reg_write;
                ex_slot_d.hilo_write = dec_hilo_write;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dec_valid_q    <= 1'b0;
            ex_slot_q      <= SLOT_EMPTY;
            mem_slot_q     <= SLOT_EMPTY;
            wb_slot_q      <= SLOT_EMPTY;
            ctrl_state_q   <= ST_RUN;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            dec_valid_q    <= dec_valid_d;
            ex_slot_q      <= ex_slot_d;
            mem_slot_q     <= mem_slot_d;
            wb_slot_q      <= wb_slot_d;
            ctrl_state_q   <= ctrl_state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign ctrl_state   = ctrl_state_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       hr;
        logic       hw;
        logic       redir;
    } in_t;

    typedef struct {
        in_t        in;
        logic [3:0] ctl;    // {pc_write, ifdec_write, ifdec_flush, decex_bubble}
        logic [1:0] st;
        int         stall;
        int         flush;
    } vec_t;

    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_FLUSH = 4'b1111;
    localparam logic [3:0] C_RESET = 4'b0011;

    logic Clk;
    logic Rst;
    in_t  in_a, in_b, in_c;

    logic        pc_a, ifw_a, ifl_a, bub_a;
    logic [1:0]  st_a;
    logic [15:0] sc_a, fc_a;
    logic        pc_b, ifw_b, ifl_b, bub_b;
    logic [1:0]  st_b;
    logic [15:0] sc_b, fc_b;
    logic        pc_c, ifw_c, ifl_c, bub_c;
    logic [1:0]  st_c;
    logic [3:0]  sc_c, fc_c;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(.CNT_W(16), .WB_HAZARD(1'b1)) u_dut_a (
        .Clk(Clk), .Rst(Rst),
        .dec_rs(in_a.rs), .dec_rt(in_a.rt), .dec_use_rs(in_a.urs), .dec_use_rt(in_a.urt),
        .dec_dest(in_a.dest), .dec_reg_write(in_a.rw), .dec_hilo_read(in_a.hr),
        .dec_hilo_write(in_a.hw), .ex_redirect(in_a.redir),
        .pc_write(pc_a), .ifdec_write(ifw_a), .ifdec_flush(ifl_a), .decex_bubble(bub_a),
        .ctrl_state(st_a), .stall_cycles(sc_a), .flush_events(fc_a)
    );

    hazard_stall_ctrl #(.CNT_W(16), .WB_HAZARD(1'b0)) u_dut_b (
        .Clk(Clk), .Rst(Rst),
        .dec_rs(in_b.rs), .dec_rt(in_b.rt), .dec_use_rs(in_b.urs), .dec_use_rt(in_b.urt),
        .dec_dest(in_b.dest), .dec_reg_write(in_b.rw), .dec_hilo_read(in_b.hr),
        .dec_hilo_write(in_b.hw), .ex_redirect(in_b.redir),
        .pc_write(pc_b), .ifdec_write(ifw_b), .ifdec_flush(ifl_b), .decex_bubble(bub_b),
        .ctrl_state(st_b), .stall_cycles(sc_b), .flush_events(fc_b)
    );

    hazard_stall_ctrl #(.CNT_W(4), .WB_HAZARD(1'b1)) u_dut_c (
        .Clk(Clk), .Rst(Rst),
        .dec_rs(in_c.rs), .dec_rt(in_c.rt), .dec_use_rs(in_c.urs), .dec_use_rt(in_c.urt),
        .dec_dest(in_c.dest), .dec_reg_write(in_c.rw), .dec_hilo_read(in_c.hr),
        .dec_hilo_write(in_c.hw), .ex_redirect(in_c.redir),
        .pc_write(pc_c), .ifdec_write(ifw_c), .ifdec_flush(ifl_c), .decex_bubble(bub_c),
        .ctrl_state(st_c), .stall_cycles(sc_c), .flush_events(fc_c)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk(input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt,
                               input logic [4:0] dest, input logic rw,
                               input logic hr, input logic hw, input logic redir);
        in_t r;
        r.rs = rs; r.urs = urs; r.rt = rt; r.urt = urt; r.dest = dest;
        r.rw = rw; r.hr = hr; r.hw = hw; r.redir = redir;
        return r;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual %0h required %0h", name, idx, act, exp);
        end
    endtask

    vec_t tbl[$];
    vec_t exp_q[$];

    task automatic add_row(input in_t i, input logic [3:0] c, input logic [1:0] s,
                           input int sc, input int fc);
        vec_t v;
        v.in = i; v.ctl = c; v.st = s; v.stall = sc; v.flush = fc;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus just after the rising edge.
    task automatic drive(input in_t a, input in_t b, input in_t c);
        @(posedge Clk);
        #1;
        in_a = a;
        in_b = b;
        in_c = c;
    endtask

    in_t NOP, P8, C8, P0, R0, MULT, MFLO, P9, R9, R9X, RD;

    initial begin
        NOP  = '0;
        P8   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0);
        C8   = mk(5'd8, 1'b1, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0);
        P0   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        R0   = mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        MULT = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);
        MFLO = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        P9   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0);
        R9   = mk(5'd9, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        R9X  = mk(5'd9, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        RD   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);

        // inputs, controls, ctrl_state (previous decision), stall count, flush count
        add_row(NOP,  C_RUN,   2'd0, 0, 0);
        add_row(P8,   C_RUN,   2'd0, 0, 0);
        add_row(C8,   C_STALL, 2'd0, 0, 0);   // hit in EX
        add_row(C8,   C_STALL, 2'd1, 1, 0);   // hit in MEM
        add_row(C8,   C_STALL, 2'd1, 2, 0);   // hit in WB
        add_row(C8,   C_RUN,   2'd1, 3, 0);
        add_row(P0,   C_RUN,   2'd0, 3, 0);
        add_row(R0,   C_RUN,   2'd0, 3, 0);   // $0 never interlocks
        add_row(MULT, C_RUN,   2'd0, 3, 0);
        add_row(MFLO, C_STALL, 2'd0, 3, 0);
        add_row(MFLO, C_STALL, 2'd1, 4, 0);
        add_row(MFLO, C_STALL, 2'd1, 5, 0);
        add_row(MFLO, C_RUN,   2'd1, 6, 0);
        add_row(MULT, C_RUN,   2'd0, 6, 0);
        add_row(NOP,  C_RUN,   2'd0, 6, 0);
        add_row(NOP,  C_RUN,   2'd0, 6, 0);
        add_row(NOP,  C_RUN,   2'd0, 6, 0);
        add_row(MFLO, C_RUN,   2'd0, 6, 0);   // mult has drained out
        add_row(P9,   C_RUN,   2'd0, 6, 0);
        add_row(R9,   C_STALL, 2'd0, 6, 0);
        add_row(R9X,  C_FLUSH, 2'd1, 7, 0);   // redirect overrides stall
        add_row(R9,   C_RUN,   2'd2, 7, 1);   // squashed DEC does not stall
        add_row(R9,   C_RUN,   2'd0, 7, 1);
        add_row(RD,   C_FLUSH, 2'd0, 7, 1);
        add_row(RD,   C_FLUSH, 2'd2, 7, 2);
        add_row(NOP,  C_RUN,   2'd2, 7, 3);
        add_row(NOP,  C_RUN,   2'd0, 7, 3);

        in_a = NOP; in_b = NOP; in_c = NOP;
        Rst  = 1'b0;

        // ---- reset: outputs forced, counters clear ----
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_ctl", i, {28'd0, pc_a, ifw_a, ifl_a, bub_a}, {28'd0, C_RESET});
            check("rst_cnt", i, {sc_a, fc_a}, 32'd0);
        end
        check("rst_state", 0, {30'd0, st_a}, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // ---- table-driven main sequence (scoreboarded) ----
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            drive(tbl[i].in, NOP, NOP);
            exp_q.push_back(tbl[i]);
            @(negedge Clk);
            e = exp_q.pop_front();
            check("tbl_ctl",   i, {28'd0, pc_a, ifw_a, ifl_a, bub_a}, {28'd0, e.ctl});
            check("tbl_state", i, {30'd0, st_a}, {30'd0, e.st});
            check("tbl_stall", i, {16'd0, sc_a}, e.stall);
            check("tbl_flush", i, {16'd0, fc_a}, e.flush);
        end

        // ---- WB_HAZARD=0: dependence on EX stalls only 2 cycles ----
        begin
            logic [3:0] seq_b [5];
            in_t        in_bs [5];
            seq_b[0] = C_RUN;   in_bs[0] = P8;
            seq_b[1] = C_STALL; in_bs[1] = C8;
            seq_b[2] = C_STALL; in_bs[2] = C8;
            seq_b[3] = C_RUN;   in_bs[3] = C8;
            seq_b[4] = C_RUN;   in_bs[4] = NOP;
            for (int i = 0; i < 5; i++) begin
                drive(NOP, in_bs[i], NOP);
                @(negedge Clk);
                check("nowb_ctl", i, {28'd0, pc_b, ifw_b, ifl_b, bub_b}, {28'd0, seq_b[i]});
            end
            check("nowb_stall", 0, {16'd0, sc_b}, 32'd2);
        end

        // ---- saturation: CNT_W=4, 21 stall cycles hold at 15 ----
        for (int r = 0; r < 7; r++) begin
            drive(NOP, NOP, P8);
            for (int k = 0; k < 4; k++) begin
                drive(NOP, NOP, C8);
                @(negedge Clk);
                if (r == 6 && k == 1)
                    check("sat_ctl", k, {28'd0, pc_c, ifw_c, ifl_c, bub_c}, {28'd0, C_STALL});
            end
            if (r == 0) check("sat_first", r, {28'd0, sc_c}, 32'd3);
        end
        drive(NOP, NOP, NOP);
        @(negedge Clk);
        check("sat_hold", 0, {28'd0, sc_c}, 32'd15);
        check("sat_flush", 0, {28'd0, fc_c}, 32'd0);

        // ---- asynchronous reset in the middle of a stall ----
        drive(P8, NOP, NOP);
        drive(C8, NOP, NOP);
        @(negedge Clk);
        check("mid_stall", 0, {28'd0, pc_a, ifw_a, ifl_a, bub_a}, {28'd0, C_STALL});
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        check("arst_ctl",   0, {28'd0, pc_a, ifw_a, ifl_a, bub_a}, {28'd0, C_RESET});
        check("arst_cnt",   0, {sc_a, fc_a}, 32'd0);
        check("arst_state", 0, {30'd0, st_a}, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("post_arst_ctl", i, {28'd0, pc_a, ifw_a, ifl_a, bub_a}, {28'd0, C_RUN});
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
        check("post_arst_stall", 0, {16'd0, sc_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
